// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM pin in clk_i cycles.
// Optional glitch filter between synchronizer and edge detector: define PWMCAP_GLITCH_FILTER_EN.
module pwm_capture #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 3
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             en_i,
   input  logic             pwm_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             timeout_o,
   output logic             level_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_raw;
   logic                   s;
   logic                   s_d;
   logic                   rise;
   logic                   fall;

   // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      end
   end

   assign s_raw = sync_q[SYNC_STAGES-1];

`ifdef PWMCAP_GLITCH_FILTER_EN
   localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic [FW-1:0] filt_cnt_q;
   logic          filt_q;

   // Counts consecutive samples that disagree with the filtered level; flips on the FILT_LEN-th.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         filt_cnt_q <= '0;
         filt_q     <= 1'b0;
      end else if (s_raw == filt_q) begin
         filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
         filt_cnt_q <= '0;
         filt_q     <= s_raw;
      end else begin
         filt_cnt_q <= filt_cnt_q + FW'(1);
      end
   end

   assign s = filt_q;
`else
   // FILT_LEN only matters when the glitch filter is built.
   logic unused_filt_len;
   assign unused_filt_len = (FILT_LEN == 0);
   assign s = s_raw;
`endif

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         s_d <= 1'b0;
      end else begin
         s_d <= s;
      end
   end

   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] cnt_per_q, cnt_per_d;
   logic [CNT_W-1:0] cnt_hi_q,  cnt_hi_d;
   logic [CNT_W-1:0] period_q,  period_d;
   logic [CNT_W-1:0] high_q,    high_d;
   logic             valid_q,   valid_d;
   logic             timeout_q, timeout_d;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         cnt_per_q <= '0;
         cnt_hi_q  <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_per_q <= cnt_per_d;
         cnt_hi_q  <= cnt_hi_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_per_d = cnt_per_q;
      cnt_hi_d  = cnt_hi_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;

      if (!en_i) begin
         state_d   = IDLE;
         cnt_per_d = '0;
         cnt_hi_d  = '0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_per_d = '0;
               cnt_hi_d  = '0;
               if (rise) begin
                  state_d   = HIGH;
                  cnt_per_d = CNT_ONE;
                  cnt_hi_d  = CNT_ONE;
               end
            end
            HIGH: begin
               if (cnt_per_q == CNT_MAX) begin
                  state_d   = IDLE;
                  cnt_per_d = '0;
                  cnt_hi_d  = '0;
                  timeout_d = 1'b1;
               end else begin
                  cnt_per_d = cnt_per_q + CNT_ONE;
                  if (fall) begin
                     state_d = LOW;
                  end else begin
                     cnt_hi_d = cnt_hi_q + CNT_ONE;
                  end
               end
            end
            LOW: begin
               // A rise at terminal count still closes a valid measurement.
               if (rise) begin
                  period_d  = cnt_per_q;
                  high_d    = cnt_hi_q;
                  valid_d   = 1'b1;
                  timeout_d = 1'b0;
                  state_d   = HIGH;
                  cnt_per_d = CNT_ONE;
                  cnt_hi_d  = CNT_ONE;
               end else if (cnt_per_q == CNT_MAX) begin
                  state_d   = IDLE;
                  cnt_per_d = '0;
                  cnt_hi_d  = '0;
                  timeout_d = 1'b1;
               end else begin
                  cnt_per_d = cnt_per_q + CNT_ONE;
               end
            end
            default: begin
               state_d   = IDLE;
               cnt_per_d = '0;
               cnt_hi_d  = '0;
            end
         endcase
      end
   end

   assign period_o  = period_q;
   assign high_o    = high_q;
   assign valid_o   = valid_q;
   assign timeout_o = timeout_q;
   assign level_o   = s;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed table, corner sequences and random PWM,
// every cycle compared against a timestamp-based reference model.
module tb_pwm_capture;

   localparam int CNT_W       = 8;
   localparam int SYNC_STAGES = 2;
   localparam int FILT_LEN    = 3;
   localparam int MAXC        = (1 << CNT_W) - 1;
   localparam int NMAX        = 20000;
`ifdef PWMCAP_GLITCH_FILTER_EN
   localparam int LAT = SYNC_STAGES + FILT_LEN + 1;
`else
   localparam int LAT = SYNC_STAGES + 1;
`endif

   logic             clk_i  = 1'b0;
   logic             rstn_i = 1'b0;
   logic             en_i   = 1'b0;
   logic             pwm_i  = 1'b0;
   logic [CNT_W-1:0] period_o;
   logic [CNT_W-1:0] high_o;
   logic             valid_o;
   logic             timeout_o;
   logic             level_o;

   pwm_capture #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
   ) dut (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .en_i     (en_i),
      .pwm_i    (pwm_i),
      .period_o (period_o),
      .high_o   (high_o),
      .valid_o  (valid_o),
      .timeout_o(timeout_o),
      .level_o  (level_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int n      = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, n);
      end
   endtask

   // Reference model: pin and level histories indexed by clock edge, measurements from timestamps.
   bit pin_h [NMAX];
   bit lvl_s [NMAX];
   bit lvl_l [NMAX];
   int last_rst = 0;
   bit armed    = 1'b0;
   int t_rise   = 0;
   int t_fall   = 0;
   int m_per    = 0;
   int m_hi     = 0;
   bit m_valid  = 1'b0;
   bit m_tmo    = 1'b0;

   function automatic bit s_at(input int i);
      return (i < 0) ? 1'b0 : lvl_s[i];
   endfunction

   function automatic void model_edge(input bit rst, input bit en, input bit pin);
      bit r;
      bit f;
      bit all_eq;
      int el;
      pin_h[n] = pin;
      if (rst) begin
         last_rst = n;
         lvl_s[n] = 1'b0;
         lvl_l[n] = 1'b0;
         armed    = 1'b0;
         m_per    = 0;
         m_hi     = 0;
         m_valid  = 1'b0;
         m_tmo    = 1'b0;
         return;
      end
      lvl_s[n] = (n - SYNC_STAGES + 1 > last_rst) ? pin_h[n - SYNC_STAGES + 1] : 1'b0;
`ifdef PWMCAP_GLITCH_FILTER_EN
      all_eq = 1'b1;
      for (int k = 1; k <= FILT_LEN; k++) begin
         if (s_at(n - k) != s_at(n - 1)) all_eq = 1'b0;
      end
      lvl_l[n] = all_eq ? s_at(n - 1) : lvl_l[n - 1];
`else
      all_eq   = 1'b0;
      lvl_l[n] = lvl_s[n];
`endif
      r = lvl_l[n - 1] & ~lvl_l[n - 2];
      f = ~lvl_l[n - 1] & lvl_l[n - 2];
      m_valid = 1'b0;
      if (!en) begin
         armed = 1'b0;
         m_tmo = 1'b0;
      end else if (!armed) begin
         if (r) begin
            armed  = 1'b1;
            t_rise = n - 1;
         end
      end else begin
         el = (n - 1) - t_rise;
         if (r) begin
            m_per   = el;
            m_hi    = t_fall - t_rise;
            m_valid = 1'b1;
            m_tmo   = 1'b0;
            t_rise  = n - 1;
         end else if (el == MAXC) begin
            m_tmo = 1'b1;
            armed = 1'b0;
         end else if (f) begin
            t_fall = n - 1;
         end
      end
   endfunction

   task automatic tick(input bit rst, input bit en, input bit pin);
      rstn_i = ~rst;
      en_i   = en;
      pwm_i  = pin;
      @(posedge clk_i);
      n++;
      if (n >= NMAX - 1) begin
         $display("FAIL cycle_budget: got %0d edges, expected fewer than %0d", n, NMAX - 1);
         $fatal(1, "cycle budget exhausted");
      end
      model_edge(rst, en, pin);
      #1;
      check("period_o", 32'(period_o), m_per);
      check("high_o", 32'(high_o), m_hi);
      check("valid_o", 32'(valid_o), 32'(m_valid));
      check("timeout_o", 32'(timeout_o), 32'(m_tmo));
      check("level_o", 32'(level_o), 32'(lvl_l[n]));
   endtask

   typedef struct {
      int hi;
      int lo;
      int reps;
      int pulses;
      int exp_per;
      int exp_hi;
   } vec_t;

   vec_t vecs [5];
   int   exp_v [7] = '{1, 1, 0, 1, 0, 0, 1};

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int np;
      int lat;
      int wait_t;
      int quiet_bad;
      int first_v;
      int tmo_before;
      int tmo_at_first;
      int nv;
      int lev;
      int len;
      bit glitch_pin;

      vecs[0] = '{3, 7, 4, 3, 10, 3};
      vecs[1] = '{8, 2, 3, 3, 10, 8};
      vecs[2] = '{5, 11, 3, 3, 16, 5};
      vecs[3] = '{3, 252, 2, 2, 255, 3};
      vecs[4] = '{1, 1, 6, 5, 2, 1};

      // Reset with the pin toggling.
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, i[0]);
      check("rst_period", 32'(period_o), 0);
      check("rst_high", 32'(high_o), 0);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_timeout", 32'(timeout_o), 0);
      check("rst_level", 32'(level_o), 0);

      // Released but disabled: no measurement activity.
      quiet_bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b0, i[1]);
         if (valid_o || timeout_o || period_o != '0 || high_o != '0) quiet_bad++;
      end
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
      check("idle_quiet", quiet_bad, 0);

      // Steady PWM table; the first pulse of each row reports the previous waveform.
      for (int v = 0; v < 5; v++) begin
         np = 0;
         for (int r = 0; r < vecs[v].reps; r++) begin
            for (int c = 0; c < vecs[v].hi + vecs[v].lo; c++) begin
               tick(1'b0, 1'b1, c < vecs[v].hi);
               if (valid_o) begin
                  np++;
                  if (np >= 2) begin
                     check("tbl_period", 32'(period_o), vecs[v].exp_per);
                     check("tbl_high", 32'(high_o), vecs[v].exp_hi);
                  end
               end
            end
         end
         check("tbl_pulses", np, vecs[v].pulses);
      end

      // Latency, then timeout with the pin held low.
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) tick(1'b0, 1'b1, c < 3);
      lat = 0;
      do begin
         tick(1'b0, 1'b1, lat < 3);
         lat++;
      end while (!valid_o && lat < 20);
      check("latency", lat, LAT);
      check("lat_period", 32'(period_o), 10);
      check("lat_high", 32'(high_o), 3);
      wait_t = 0;
      while (!timeout_o && wait_t < 400) begin
         tick(1'b0, 1'b1, 1'b0);
         wait_t++;
      end
      check("timeout_delay", wait_t, MAXC);
      check("tmo_period_hold", 32'(period_o), 10);
      check("tmo_high_hold", 32'(high_o), 3);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
      check("tmo_sticky", 32'(timeout_o), 1);

      // Restart: first rise only arms; the second rise reports and clears the timeout.
      first_v      = -1;
      tmo_before   = -1;
      tmo_at_first = -1;
      for (int t = 0; t < 30; t++) begin
         tick(1'b0, 1'b1, (t % 10) < 3);
         if (t == 9) tmo_before = int'(timeout_o);
         if (valid_o && first_v < 0) begin
            first_v      = t;
            tmo_at_first = int'(timeout_o);
         end
      end
      check("restart_first_valid", first_v, 10 + LAT - 1);
      check("restart_tmo_before", tmo_before, 1);
      check("restart_tmo_cleared", tmo_at_first, 0);

      // Enable drops: mid-period, and on the very edge a report would be issued.
      for (int r = 0; r < 7; r++) begin
         nv = 0;
         for (int c = 0; c < 10; c++) begin
            tick(1'b0, !((r == 1 && c == 5) || (r == 4 && c == LAT - 1)), c < 3);
            if (valid_o) begin
               nv++;
               check("endrop_period", 32'(period_o), 10);
            end
         end
         check("endrop_pulses", nv, exp_v[r]);
      end

      // One-cycle low glitch inside a 6-cycle high phase of a 16-cycle period.
      tick(1'b0, 1'b0, 1'b0);
      np = 0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 16; c++) begin
            glitch_pin = (c < 3) || (c == 4) || (c == 5);
            tick(1'b0, 1'b1, glitch_pin);
            if (valid_o && r >= 1) begin
               np++;
`ifdef PWMCAP_GLITCH_FILTER_EN
               check("glitch_period", 32'(period_o), 16);
               check("glitch_high", 32'(high_o), 6);
`else
               check("glitch_period", 32'(period_o), (c == LAT - 1) ? 12 : 4);
               check("glitch_high", 32'(high_o), (c == LAT - 1) ? 2 : 3);
`endif
            end
         end
      end
`ifdef PWMCAP_GLITCH_FILTER_EN
      check("glitch_pulses", np, 4);
`else
      check("glitch_pulses", np, 8);
`endif

      // Random PWM with occasional enable drops and resets.
      lev = 0;
      np  = 0;
      for (int seg = 0; seg < 150; seg++) begin
         len = int'($urandom_range(1, 14));
         lev = 1 - lev;
         for (int c = 0; c < len; c++) begin
            tick($urandom_range(0, 399) == 0, $urandom_range(0, 63) != 0, lev[0]);
            if (valid_o) np++;
         end
      end
      check("rand_activity", np > 10, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
